// File: rtl/fifo_flex.sv
// fifo_flex: synchronous FIFO with level/almost flags, sticky error flags and optional FWFT read port
// Macro FIFO_FLEX_FWFT_EN selects first-word-fall-through; undefined gives registered reads (latency 1).
// Ports: clk_i clock, rst_i async active-low reset, clear_i sync flush,
//   wr_en/data_i write side, rd_en/data_o/valid_o read side,
//   full_o/empty_o/almost_full_o/almost_empty_o/level_o status,
//   overflow_o/underflow_o sticky errors (write while full / read while empty).
module fifo_flex #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign full_o         = level_o == LW'(DEPTH);
  assign empty_o        = level_o == '0;
  assign almost_full_o  = level_o >= LW'(AF_THRESH);
  assign almost_empty_o = level_o <= LW'(AE_THRESH);
  // clear overrides both requests; acceptance uses the pre-edge flags
  assign wr_ok = wr_en && !full_o && !clear_i;
  assign rd_ok = rd_en && !empty_o && !clear_i;
  always_ff @(posedge clk_i)
    if (wr_ok) mem[wr_ptr] <= data_i;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(wr_ok);
      rd_ptr      <= rd_ptr + AW'(rd_ok);
      level_o     <= level_o + LW'(wr_ok) - LW'(rd_ok);
      overflow_o  <= overflow_o | (wr_en & full_o);
      underflow_o <= underflow_o | (rd_en & empty_o);
    end
`ifdef FIFO_FLEX_FWFT_EN
  // head entry is visible as soon as the FIFO holds anything; zero while empty
  assign valid_o = !empty_o;
  assign data_o  = empty_o ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else begin
      valid_o <= rd_ok;
      if (rd_ok) data_o <= mem[rd_ptr];
    end
`endif
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: randomized + directed self-checking bench for fifo_flex against a queue-based model
module tb_fifo_flex;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int LW = 4;
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic [W-1:0]  data_o;
  logic          valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [LW-1:0] level_o;
  logic          overflow_o, underflow_o;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] q[$];
  logic         m_ovf, m_unf, m_valid;
  logic [W-1:0] m_data;

  fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .wr_en(wr_en), .data_i(data_i), .rd_en(rd_en),
    .data_o(data_o), .valid_o(valid_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .level_o(level_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, "_level"}, 32'(level_o), n);
    chk({tag, "_full"}, 32'(full_o), 32'(n == D));
    chk({tag, "_empty"}, 32'(empty_o), 32'(n == 0));
    chk({tag, "_afull"}, 32'(almost_full_o), 32'(n >= 6));
    chk({tag, "_aempty"}, 32'(almost_empty_o), 32'(n <= 2));
    chk({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(underflow_o), 32'(m_unf));
`ifdef FIFO_FLEX_FWFT_EN
    chk({tag, "_valid"}, 32'(valid_o), 32'(n != 0));
    chk({tag, "_data"}, 32'(data_o), (n != 0) ? 32'(q[0]) : 32'h0);
`else
    chk({tag, "_valid"}, 32'(valid_o), 32'(m_valid));
    chk({tag, "_data"}, 32'(data_o), 32'(m_data));
`endif
  endtask

  // one clock: drive, let the edge happen, advance the model from pre-edge state, check 1ns later
  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    logic full, empty;
    logic [W-1:0] popped;
    wr_en = w; data_i = d; rd_en = r; clear_i = c;
    @(posedge clk_i);
    full  = (q.size() == D);
    empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_valid = 1'b0;
    end else begin
      if (w && full) m_ovf = 1'b1;
      if (r && empty) m_unf = 1'b1;
      m_valid = 1'b0;
      if (r && !empty) begin
        popped = q.pop_front();
        m_data = popped;
        m_valid = 1'b1;
      end
      if (w && !full) q.push_back(d);
    end
    #1;
    check_all("step");
    wr_en = 1'b0; rd_en = 1'b0; clear_i = 1'b0;
  endtask

  initial begin
    int wp, rp;
    model_reset();
    #1;
    check_all("por");
    #10 rst_i = 1'b1;
    // fill then drain
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full_o), 32'h1);
    chk("fill_level", 32'(level_o), 32'h8);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty_o), 32'h1);
    // overflow / underflow / clear
    for (int i = 0; i < 9; i++) step(1'b1, W'(16'h100 + i), 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow_o), 32'h1);
    chk("ovf_level", 32'(level_o), 32'h8);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("unf_set", 32'(underflow_o), 32'h1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow_o), 32'h0);
    chk("clr_unf", 32'(underflow_o), 32'h0);
    // simultaneous access at level 4, 8 and 0
    for (int i = 0; i < 4; i++) step(1'b1, W'(16'h200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, W'(16'h300 + i), 1'b1, 1'b0);
    chk("sim4_level", 32'(level_o), 32'h4);
    for (int i = 0; i < 4; i++) step(1'b1, W'(16'h400 + i), 1'b0, 1'b0);
    step(1'b1, 16'h0dead, 1'b1, 1'b0);
    chk("sim8_level", 32'(level_o), 32'h7);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0123, 1'b1, 1'b0);
    chk("sim0_level", 32'(level_o), 32'h1);
    // reset mid-stream at level 5, asserted between edges
    for (int i = 0; i < 4; i++) step(1'b1, W'(16'h500 + i), 1'b0, 1'b0);
    #3 rst_i = 1'b0;
    model_reset();
    #1;
    check_all("arst");
    chk("arst_level", 32'(level_o), 32'h0);
    #2 rst_i = 1'b1;
    step(1'b1, 16'hbeef, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
`ifndef FIFO_FLEX_FWFT_EN
    chk("beef_data", 32'(data_o), 32'hbeef);
`endif
    // mode check
    step(1'b1, 16'ha5a5, 1'b0, 1'b0);
`ifdef FIFO_FLEX_FWFT_EN
    chk("fwft_valid", 32'(valid_o), 32'h1);
    chk("fwft_data", 32'(data_o), 32'ha5a5);
    step(1'b0, '0, 1'b1, 1'b0);
`else
    chk("std_novalid", 32'(valid_o), 32'h0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("std_valid", 32'(valid_o), 32'h1);
    chk("std_data", 32'(data_o), 32'ha5a5);
`endif
    // randomized traffic with shifting write/read bias and rare flushes
    wp = 50; rp = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        wp = $urandom_range(15, 85);
        rp = $urandom_range(15, 85);
      end
      step(1'($urandom_range(0, 99) < wp), W'($urandom), 1'($urandom_range(0, 99) < rp),
           1'($urandom_range(0, 63) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of entries; power of two, minimum 2.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-2; almost_full_o asserts when level >= AF_THRESH.
REQ-004 The block SHALL have parameter AE_THRESH, default 2; almost_empty_o asserts when level <= AE_THRESH.
REQ-005 The block SHALL have port clk_i, input, 1 bit, clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit, reset, asynchronous, active-low.
REQ-007 The block SHALL have port clear_i, input, 1 bit, synchronous flush.
REQ-008 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-009 The block SHALL have port data_i, input, WIDTH bits, write data.
REQ-010 The block SHALL have port rd_en, input, 1 bit, read request or pop.
REQ-011 The block SHALL have port data_o, output, WIDTH bits, read data.
REQ-012 The block SHALL have port valid_o, output, 1 bit, data_o qualifier.
REQ-013 The block SHALL have ports full_o, empty_o, almost_full_o and almost_empty_o, each output, 1 bit, status flags.
REQ-014 The block SHALL have port level_o, output, $clog2(DEPTH)+1 bits, current entry count.
REQ-015 The block SHALL have ports overflow_o and underflow_o, each output, 1 bit, sticky error flags.

Function
REQ-016 A write SHALL be accepted when wr_en=1 and full_o=0; data_i is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-017 A read SHALL be accepted when rd_en=1 and empty_o=0; rd_ptr increments modulo DEPTH.
REQ-018 Acceptance SHALL be decided from flags sampled before the clock edge: when full with both requests, only the read is accepted; when empty with both requests, only the write is accepted; otherwise both are accepted.
REQ-019 level_o SHALL change by +1 on a write only, -1 on a read only, and 0 on both or neither; it never exceeds DEPTH and never wraps below 0.
REQ-020 full_o SHALL equal (level_o==DEPTH) and empty_o SHALL equal (level_o==0); both flags and both almost flags derive combinationally from the registered level.
REQ-021 overflow_o SHALL set on any cycle with wr_en=1 and full_o=1, and underflow_o SHALL set on any cycle with rd_en=1 and empty_o=1; both hold until clear_i or reset.
REQ-022 clear_i=1 SHALL zero both pointers, level_o, overflow_o, underflow_o and valid_o on the next edge, overriding wr_en and rd_en in that cycle; storage contents are don't-care afterwards.
REQ-023 A rejected request SHALL change no state other than the sticky error flags.
REQ-024 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless, with no bubble and no data loss.

Reset
REQ-025 While rst_i=0 the block SHALL immediately force pointers=0, level_o=0, data_o=0, valid_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0 and underflow_o=0.
REQ-026 Storage SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL discard all pending entries, and the first accepted write after release SHALL be the first word read.

Configuration
REQ-028 With macro FIFO_FLEX_FWFT_EN defined, the block SHALL operate first-word-fall-through: data_o shows the head entry whenever empty_o=0; valid_o=!empty_o; rd_en pops the head; a write into an empty FIFO makes valid_o=1 one cycle after the accepting edge.
REQ-029 With FIFO_FLEX_FWFT_EN undefined, the block SHALL operate in standard mode: on an accepted read, data_o is registered with the head entry and valid_o=1 for exactly the following cycle; otherwise valid_o=0 and data_o holds its last value (read latency 1).

Verification
REQ-030 The bench SHALL cover fill/drain (WIDTH=16, DEPTH=8, AF=6, AE=2): write 0x0001..0x0008 -> full_o=1 and level_o=8 after the 8th edge, almost_full_o=1 from level 6; then read 8 -> data_o sequence 0x0001..0x0008 in order, empty_o=1 at end.
REQ-031 The bench SHALL cover overflow/underflow: write 9 words into the empty FIFO -> 9th rejected, overflow_o=1, level_o=8; drain then rd_en on empty -> underflow_o=1; clear_i pulse -> both flags 0 and level_o=0.
REQ-032 The bench SHALL cover simultaneous access: at level 4 with wr_en=rd_en=1 for 20 cycles -> level_o stays 4, pointers wrap, data order preserved; at level 8 with both requests -> level_o=7; at level 0 with both requests -> level_o=1.
REQ-033 The bench SHALL cover reset mid-stream: at level 5, pull rst_i low asynchronously between edges -> all outputs take reset values immediately; write 0xBEEF then read -> 0xBEEF returned.
REQ-034 The bench SHALL cover mode check: in FWFT, write 0xA5A5 into the empty FIFO -> valid_o=1 and data_o=0xA5A5 next cycle, no rd_en needed; in standard mode, rd_en -> data_o=0xA5A5 with valid_o=1 one cycle later.
